// File: rtl/tsn_sched_pkg.sv
// Shared definitions for the TSN scheduler front-end blocks.
package tsn_sched_pkg;

    // Decision reason codes reported alongside every accept/drop.
    localparam logic [1:0] REASON_OK   = 2'd0;
    localparam logic [1:0] REASON_FULL = 2'd1;
    localparam logic [1:0] REASON_MAX  = 2'd2;
    localparam logic [1:0] REASON_RED  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StDecide,
        StUpdate
    } admit_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/admit_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low OUT_W bits as the random draw.
module admit_lfsr16
    import tsn_sched_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED,
    parameter logic [15:0] TAPS  = LFSR_TAPS,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = ^(r_lfsr & TAPS);

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/enqueue_admit_ctrl.sv
// Enqueue admission controller: owns per-queue occupancy and the shared free-cache
// count, and issues an accept/drop decision (tail-drop or RED) for each request.
module enqueue_admit_ctrl
    import tsn_sched_pkg::*;
#(
    parameter int unsigned      NUM_PORTS       = 4,
    parameter int unsigned      QUEUES_PER_PORT = 8,
    parameter int unsigned      LEN_W           = 11,
    parameter int unsigned      OCC_W           = 12,
    parameter int unsigned      CACHE_DEPTH     = 2047,
    parameter logic [OCC_W-1:0] TH_MIN          = 12'h034,
    parameter logic [OCC_W-1:0] TH_MAX          = 12'h14A,
    parameter int unsigned      MODE            = 0
) (
    input  logic                               clk_in,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [$clog2(NUM_PORTS)-1:0]       req_port,
    input  logic [$clog2(QUEUES_PER_PORT)-1:0] req_queue,
    input  logic [LEN_W-1:0]                   req_len,
    input  logic                               rel_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]       rel_port,
    input  logic [$clog2(QUEUES_PER_PORT)-1:0] rel_queue,
    input  logic [LEN_W-1:0]                   rel_len,
    output logic                               dec_valid,
    output logic                               dec_accept,
    output logic [1:0]                         dec_reason,
    output logic [$clog2(NUM_PORTS)-1:0]       dec_port,
    output logic [$clog2(QUEUES_PER_PORT)-1:0] dec_queue,
    output logic [OCC_W-1:0]                   dec_occ,
    output logic [$clog2(CACHE_DEPTH+1)-1:0]   free_cache,
    output logic                               err_underflow
);

    localparam int unsigned PORT_W  = $clog2(NUM_PORTS);
    localparam int unsigned QUEUE_W = $clog2(QUEUES_PER_PORT);
    localparam int unsigned NUM_Q   = NUM_PORTS * QUEUES_PER_PORT;
    localparam int unsigned IDX_W   = PORT_W + QUEUE_W;
    localparam int unsigned FREE_W  = $clog2(CACHE_DEPTH + 1);
    localparam int unsigned CW      = 32;

    admit_state_e       r_state;
    logic [PORT_W-1:0]  r_port;
    logic [QUEUE_W-1:0] r_queue;
    logic [LEN_W-1:0]   r_len;
    logic [OCC_W-1:0]   r_occ;
    logic [OCC_W:0]     r_sum;
    logic               r_accept;
    logic               r_dec_valid;
    logic               r_dec_accept;
    logic [1:0]         r_dec_reason;
    logic [OCC_W-1:0]   r_dec_occ;
    logic [OCC_W-1:0]   r_occ_arr [NUM_Q];
    logic [FREE_W-1:0]  r_free;
    logic               r_err;

    logic [OCC_W-1:0]   w_occ_nxt [NUM_Q];
    logic [FREE_W-1:0]  w_free_nxt;
    logic [CW-1:0]      w_free_calc;
    logic               w_err_set;
    logic [OCC_W-1:0]   w_lfsr;
    logic [IDX_W-1:0]   w_req_idx;
    logic [IDX_W-1:0]   w_rel_idx;
    logic [OCC_W:0]     w_len_ext;
    logic [OCC_W:0]     w_excess;
    logic               w_apply;
    logic               w_dec_accept;
    logic [1:0]         w_dec_reason;

    // Power-of-two sizes make {port, queue} equal to port*QUEUES_PER_PORT + queue.
    assign w_req_idx = {r_port, r_queue};
    assign w_rel_idx = {rel_port, rel_queue};
    assign w_len_ext = (OCC_W + 1)'(r_len);
    assign w_excess  = r_sum - {1'b0, TH_MIN};
    assign w_apply   = (r_state == StUpdate) && r_accept;

    admit_lfsr16 #(
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (OCC_W)
    ) u_lfsr (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    // Priority-ordered admission rules evaluated in DECIDE.
    always_comb begin
        w_dec_accept = 1'b1;
        w_dec_reason = REASON_OK;
        if (r_len != '0) begin
            if (CW'(r_len) > CW'(r_free)) begin
                w_dec_accept = 1'b0;
                w_dec_reason = REASON_FULL;
            end else if (r_sum > {1'b0, TH_MAX}) begin
                w_dec_accept = 1'b0;
                w_dec_reason = REASON_MAX;
            end else if ((MODE == 1) && (r_sum > {1'b0, TH_MIN}) &&
                         ({1'b0, w_lfsr} < w_excess)) begin
                w_dec_accept = 1'b0;
                w_dec_reason = REASON_RED;
            end
        end
    end

    // Request FSM with registered decision outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_port       <= '0;
            r_queue      <= '0;
            r_len        <= '0;
            r_occ        <= '0;
            r_sum        <= '0;
            r_accept     <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_dec_accept <= 1'b0;
            r_dec_reason <= REASON_OK;
            r_dec_occ    <= '0;
        end else begin
            r_dec_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_port  <= req_port;
                        r_queue <= req_queue;
                        r_len   <= req_len;
                        r_state <= StLookup;
                    end
                end
                StLookup: begin
                    r_occ   <= r_occ_arr[w_req_idx];
                    r_sum   <= {1'b0, r_occ_arr[w_req_idx]} + w_len_ext;
                    r_state <= StDecide;
                end
                StDecide: begin
                    r_accept     <= w_dec_accept;
                    r_dec_valid  <= 1'b1;
                    r_dec_accept <= w_dec_accept;
                    r_dec_reason <= w_dec_reason;
                    r_dec_occ    <= w_dec_accept ? r_sum[OCC_W-1:0] : r_occ;
                    r_state      <= StUpdate;
                end
                StUpdate: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    // Next counter values: enqueue first, then release, with saturation on both ends.
    always_comb begin
        w_err_set = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            w_occ_nxt[i] = r_occ_arr[i];
        end
        if (w_apply) begin
            w_occ_nxt[w_req_idx] = r_occ_arr[w_req_idx] + OCC_W'(r_len);
        end
        if (rel_valid) begin
            if (CW'(rel_len) > CW'(w_occ_nxt[w_rel_idx])) begin
                w_occ_nxt[w_rel_idx] = '0;
                w_err_set            = 1'b1;
            end else begin
                w_occ_nxt[w_rel_idx] = w_occ_nxt[w_rel_idx] - OCC_W'(rel_len);
            end
        end
        w_free_calc = CW'(r_free);
        if (w_apply) begin
            w_free_calc = w_free_calc - CW'(r_len);
        end
        if (rel_valid) begin
            w_free_calc = w_free_calc + CW'(rel_len);
        end
        if (w_free_calc > CW'(CACHE_DEPTH)) begin
            w_free_calc = CW'(CACHE_DEPTH);
            w_err_set   = 1'b1;
        end
        w_free_nxt = w_free_calc[FREE_W-1:0];
    end

    // Occupancy array, free-cache count and sticky error flag.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_Q; i++) begin
                r_occ_arr[i] <= '0;
            end
            r_free <= FREE_W'(CACHE_DEPTH);
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                r_occ_arr[i] <= w_occ_nxt[i];
            end
            r_free <= w_free_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready     = (r_state == StIdle);
    assign dec_valid     = r_dec_valid;
    assign dec_accept    = r_dec_accept;
    assign dec_reason    = r_dec_reason;
    assign dec_port      = r_port;
    assign dec_queue     = r_queue;
    assign dec_occ       = r_dec_occ;
    assign free_cache    = r_free;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_enqueue_admit_ctrl.sv
// Directed bench: one tail-drop instance and one RED instance sharing clock and reset.
module tb_enqueue_admit_ctrl;

    logic        clk_in;
    logic        rst_n;
    logic [1:0]  req_port;
    logic [2:0]  req_queue;
    logic [10:0] req_len;
    logic [1:0]  rel_port;
    logic [2:0]  rel_queue;
    logic [10:0] rel_len;
    logic        req_valid0, req_valid1, rel_valid0, rel_valid1;
    logic        rdy0, rdy1, dv0, dv1, acc0, acc1, err0, err1;
    logic [1:0]  rsn0, rsn1, dport0, dport1;
    logic [2:0]  dq0, dq1;
    logic [11:0] docc0, docc1;
    logic [10:0] free0, free1;
    logic [15:0] m_lfsr;

    int n_vec = 0;
    int n_err = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    enqueue_admit_ctrl #(.MODE(0)) u_dut_td (
        .clk_in(clk_in), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(rdy0), .req_port(req_port),
        .req_queue(req_queue), .req_len(req_len),
        .rel_valid(rel_valid0), .rel_port(rel_port), .rel_queue(rel_queue), .rel_len(rel_len),
        .dec_valid(dv0), .dec_accept(acc0), .dec_reason(rsn0), .dec_port(dport0),
        .dec_queue(dq0), .dec_occ(docc0), .free_cache(free0), .err_underflow(err0)
    );

    enqueue_admit_ctrl #(.MODE(1)) u_dut_red (
        .clk_in(clk_in), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(rdy1), .req_port(req_port),
        .req_queue(req_queue), .req_len(req_len),
        .rel_valid(rel_valid1), .rel_port(rel_port), .rel_queue(rel_queue), .rel_len(rel_len),
        .dec_valid(dv1), .dec_accept(acc1), .dec_reason(rsn1), .dec_port(dport1),
        .dec_queue(dq1), .dec_occ(docc1), .free_cache(free1), .err_underflow(err1)
    );

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request; lf returns the reference LFSR value during the DECIDE cycle.
    task automatic do_req(input int d, input logic [1:0] p, input logic [2:0] q,
                          input logic [10:0] len, input logic [10:0] upd_rel,
                          output logic acc, output logic [1:0] rsn,
                          output logic [11:0] occ, output logic [15:0] lf);
        int   lat;
        logic dv;
        @(negedge clk_in);
        chk("req_ready", (d == 0) ? rdy0 : rdy1, 1'b1);
        req_port  = p;
        req_queue = q;
        req_len   = len;
        if (d == 0) req_valid0 = 1'b1;
        else        req_valid1 = 1'b1;
        lf  = '0;
        lat = 0;
        dv  = 1'b0;
        while (!dv && lat < 8) begin
            @(negedge clk_in);
            lat++;
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
            if (lat == 2) lf = m_lfsr;
            dv = (d == 0) ? dv0 : dv1;
        end
        chk("dec_latency", lat, 3);
        acc = (d == 0) ? acc0 : acc1;
        rsn = (d == 0) ? rsn0 : rsn1;
        occ = (d == 0) ? docc0 : docc1;
        chk("dec_port", (d == 0) ? dport0 : dport1, p);
        chk("dec_queue", (d == 0) ? dq0 : dq1, q);
        if (upd_rel != '0) begin
            rel_port  = p;
            rel_queue = q;
            rel_len   = upd_rel;
            if (d == 0) rel_valid0 = 1'b1;
            else        rel_valid1 = 1'b1;
            @(negedge clk_in);
            rel_valid0 = 1'b0;
            rel_valid1 = 1'b0;
        end
    endtask

    task automatic req_chk(input string tag, input logic [1:0] p, input logic [2:0] q,
                           input logic [10:0] len, input logic [10:0] upd_rel,
                           input logic e_acc, input logic [1:0] e_rsn, input logic [11:0] e_occ);
        logic        acc;
        logic [1:0]  rsn;
        logic [11:0] occ;
        logic [15:0] lf;
        do_req(0, p, q, len, upd_rel, acc, rsn, occ, lf);
        chk({tag, "_accept"}, acc, e_acc);
        chk({tag, "_reason"}, rsn, e_rsn);
        chk({tag, "_occ"}, occ, e_occ);
    endtask

    task automatic do_rel(input int d, input logic [1:0] p, input logic [2:0] q,
                          input logic [10:0] len);
        @(negedge clk_in);
        rel_port  = p;
        rel_queue = q;
        rel_len   = len;
        if (d == 0) rel_valid0 = 1'b1;
        else        rel_valid1 = 1'b1;
        @(negedge clk_in);
        rel_valid0 = 1'b0;
        rel_valid1 = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int e_free, input logic e_err);
        @(negedge clk_in);
        chk({tag, "_free"}, free0, e_free);
        chk({tag, "_err"}, err0, e_err);
    endtask

    // RED request on port 0 of the MODE=1 instance, checked against the reference rules.
    task automatic red_req(input logic [2:0] q, input int len, inout int m_occ, inout int drops);
        logic        acc, e_acc;
        logic [1:0]  rsn, e_rsn;
        logic [11:0] occ;
        logic [15:0] lf;
        int          sum;
        do_req(1, 2'd0, q, len[10:0], 11'd0, acc, rsn, occ, lf);
        sum   = m_occ + len;
        e_acc = 1'b1;
        e_rsn = 2'd0;
        if (len != 0) begin
            if (sum > 330) begin
                e_acc = 1'b0;
                e_rsn = 2'd2;
            end else if (sum > 52 && int'(lf[11:0]) < sum - 52) begin
                e_acc = 1'b0;
                e_rsn = 2'd3;
            end
        end
        chk("red_accept", acc, e_acc);
        chk("red_reason", rsn, e_rsn);
        chk("red_occ", occ, e_acc ? sum : m_occ);
        if (e_acc) m_occ = sum;
        else       drops++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m_occ;
        int drops;
        int seen;
        rst_n      = 1'b0;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        rel_valid0 = 1'b0;
        rel_valid1 = 1'b0;
        req_port   = '0;
        req_queue  = '0;
        req_len    = '0;
        rel_port   = '0;
        rel_queue  = '0;
        rel_len    = '0;

        // Reset values of both instances.
        #12;
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_dec_valid", dv0, 1'b0);
        chk("rst_accept", acc0, 1'b0);
        chk("rst_occ", docc0, 0);
        chk("rst_free", free0, 2047);
        chk("rst_err", err0, 1'b0);
        chk("rst_free_red", free1, 2047);
        chk("rst_ready_red", rdy1, 1'b1);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Single accept and one-cycle pulse width.
        req_chk("t1", 2'd0, 3'd0, 11'd3, 11'd0, 1'b1, 2'd0, 12'd3);
        @(negedge clk_in);
        chk("t1_pulse_width", dv0, 1'b0);
        chk("t1_free", free0, 2044);

        // Fill one queue up to TH_MAX.
        req_chk("t2_r1", 2'd1, 3'd2, 11'd100, 11'd0, 1'b1, 2'd0, 12'd100);
        req_chk("t2_r2", 2'd1, 3'd2, 11'd100, 11'd0, 1'b1, 2'd0, 12'd200);
        req_chk("t2_r3", 2'd1, 3'd2, 11'd100, 11'd0, 1'b1, 2'd0, 12'd300);
        req_chk("t2_r4", 2'd1, 3'd2, 11'd100, 11'd0, 1'b0, 2'd2, 12'd300);
        chk_state("t2", 1744, 1'b0);

        // Sum exactly at TH_MAX is accepted; drain free_cache to 10.
        for (int i = 0; i < 5; i++) begin
            req_chk("t3_fill", 2'd2, i[2:0], 11'd330, 11'd0, 1'b1, 2'd0, 12'd330);
        end
        req_chk("t3_fill5", 2'd2, 3'd5, 11'd84, 11'd0, 1'b1, 2'd0, 12'd84);
        chk_state("t3_ten", 10, 1'b0);
        req_chk("t3_full", 2'd3, 3'd0, 11'd11, 11'd0, 1'b0, 2'd1, 12'd0);
        do_rel(0, 2'd2, 3'd5, 11'd1);
        chk_state("t3_rel", 11, 1'b0);
        req_chk("t3_fit", 2'd3, 3'd0, 11'd11, 11'd0, 1'b1, 2'd0, 12'd11);
        chk_state("t3_empty", 0, 1'b0);
        req_chk("t3_zero_len", 2'd3, 3'd1, 11'd0, 11'd0, 1'b1, 2'd0, 12'd0);

        // Release and accept on the same queue in the UPDATE cycle.
        do_rel(0, 2'd2, 3'd0, 11'd100);
        chk_state("t5_pre", 100, 1'b0);
        req_chk("t5_upd", 2'd2, 3'd5, 11'd20, 11'd50, 1'b1, 2'd0, 12'd103);
        chk_state("t5_post", 130, 1'b0);
        req_chk("t5_occ", 2'd2, 3'd5, 11'd0, 11'd0, 1'b1, 2'd0, 12'd53);

        // Release on an empty queue.
        do_rel(0, 2'd0, 3'd7, 11'd5);
        chk_state("t6_underflow", 135, 1'b1);
        req_chk("t6_occ", 2'd0, 3'd7, 11'd0, 11'd0, 1'b1, 2'd0, 12'd0);

        // RED instance: bring port 0 queue 0 to occupancy 200.
        m_occ = 0;
        drops = 0;
        for (int k = 0; k < 40 && m_occ < 200; k++) begin
            red_req(3'd0, 100, m_occ, drops);
        end
        red_req(3'd0, 0, m_occ, drops);
        red_req(3'd0, 200, m_occ, drops);

        // 1000 decisions at sum 300 (excess 248).
        drops = 0;
        for (int k = 0; k < 1000; k++) begin
            red_req(3'd0, 100, m_occ, drops);
            if (m_occ == 300) begin
                do_rel(1, 2'd0, 3'd0, 11'd100);
                m_occ = 200;
            end
        end
        $display("red drops: %0d of 1000", drops);
        chk("red_rate_in_band", (drops >= 31 && drops <= 90), 1'b1);

        // Reset while a request is in flight.
        @(negedge clk_in);
        req_port   = 2'd1;
        req_queue  = 3'd0;
        req_len    = 11'd5;
        req_valid0 = 1'b1;
        @(negedge clk_in);
        req_valid0 = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk_in);
        chk("midrst_ready", rdy0, 1'b1);
        chk("midrst_dec_valid", dv0, 1'b0);
        chk("midrst_free", free0, 2047);
        chk("midrst_err", err0, 1'b0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (dv0) seen++;
        end
        chk("midrst_no_dec", seen, 0);
        chk("midrst_free_after", free0, 2047);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enqueue_admit_ctrl.md
Name: enqueue_admit_ctrl

Overview:
Parametrised enqueue admission controller for the TSN scheduler front end. It owns the per-queue occupancy counters and the shared free-cache counter, so these are no longer supplied by upstream. For each enqueue request it returns an accept or drop decision, with either tail-drop or min/max-threshold random early drop. Dequeue releases return buffer space. The block sits between the frame parser and the queue pointer manager.

Parameters:
NUM_PORTS, 4, number of egress ports (power of 2)
QUEUES_PER_PORT, 8, queues per port (power of 2)
LEN_W, 11, frame length width in cache units
OCC_W, 12, per-queue occupancy counter width
CACHE_DEPTH, 2047, total shared cache units; reset value of free_cache
TH_MIN, 12'h034, occupancy at or below which frames are always accepted
TH_MAX, 12'h14A, occupancy above which frames are always dropped
MODE, 0, 0 = tail-drop only; 1 = random early drop between TH_MIN and TH_MAX

Ports:
clk_in  in  1  single clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  enqueue request valid
req_ready  out  1  block can take a request
req_port  in  $clog2(NUM_PORTS)  target port
req_queue  in  $clog2(QUEUES_PER_PORT)  target queue within port
req_len  in  LEN_W  frame length
rel_valid  in  1  dequeue release strobe; always accepted
rel_port  in  $clog2(NUM_PORTS)  release port
rel_queue  in  $clog2(QUEUES_PER_PORT)  release queue
rel_len  in  LEN_W  released length
dec_valid  out  1  one-cycle decision pulse
dec_accept  out  1  1 = enqueue, 0 = drop
dec_reason  out  2  0 = ok, 1 = buffer full, 2 = above TH_MAX, 3 = early drop
dec_port  out  $clog2(NUM_PORTS)  echoed port
dec_queue  out  $clog2(QUEUES_PER_PORT)  echoed queue
dec_occ  out  OCC_W  queue occupancy after the update
free_cache  out  $clog2(CACHE_DEPTH+1)  current free units
err_underflow  out  1  sticky: release exceeded an occupancy or overfilled the cache

Behaviour:
- Reset, asynchronous: every output is 0 except req_ready = 1 and free_cache = CACHE_DEPTH. All occupancies reset to 0. FSM goes to IDLE. LFSR loads 16'hACE1.
- Reset mid-operation: an in-flight request is discarded and no dec_valid is issued.
- FSM IDLE -> LOOKUP -> DECIDE -> UPDATE -> IDLE.
  - IDLE: req_ready = 1; on req_valid, latch port, queue and len, then go to LOOKUP.
  - LOOKUP: register occ = occupancy[port*QUEUES_PER_PORT + queue] and sum = occ + len, computed at OCC_W+1 bits.
  - DECIDE: evaluate the rules below in priority order.
  - UPDATE: apply the accept, pulse dec_valid, return to IDLE.
- Latency: request handshake in cycle 0, dec_valid in cycle 3. Peak throughput is one request every 4 cycles.
- req_ready is low outside IDLE.
- Decision rules, in priority order:
  - len == 0: accept, reason 0, no counter change.
  - len > free_cache: drop, reason 1.
  - sum > TH_MAX: drop, reason 2.
  - sum <= TH_MIN, or MODE == 0: accept.
  - MODE == 1 and TH_MIN < sum <= TH_MAX: drop with reason 3 if lfsr[OCC_W-1:0] < (sum - TH_MIN); otherwise accept.
- On accept: occupancy += len and free_cache -= len.
- dec_occ is the post-update occupancy, or the unchanged occupancy on a drop.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11; advances every cycle when not in reset.
- Release: applied in the cycle it is strobed, in any FSM state. occupancy -= rel_len and free_cache += rel_len.
  - If rel_len > occupancy: occupancy saturates at 0 and err_underflow is set.
  - If free_cache would exceed CACHE_DEPTH: it saturates at CACHE_DEPTH and err_underflow is set.
- Release in the same cycle as UPDATE: both are applied, to the same or different counters. Example: free_cache_next = free_cache - len + rel_len.
- Release between LOOKUP and UPDATE on the same queue: the decision uses the stale, higher occupancy. This is conservative and allowed.
- err_underflow clears only on reset.

Decomposition:
- Shared package tsn_sched_pkg holds:
  - dec_reason encodings: REASON_OK, REASON_FULL, REASON_MAX, REASON_RED;
  - FSM state enum;
  - the LFSR seed and tap constants.
- One sub-module, admit_lfsr16: a free-running LFSR with seed parameter and enable.
- The occupancy array stays inline as a register array. It needs the parallel release port, so it is not RAM.

Test Plan:
1. Reset, then MODE = 0: request port 0, queue 0, len 3 -> dec_valid exactly 3 cycles after the handshake; accept = 1, dec_occ = 3, free_cache = 2044.
2. Fill port 1, queue 2 with len 100 requests -> requests 1-3 accepted with occ 100, 200 and 300; request 4 has sum 400 > 330 and is dropped with reason 2, occ stays 300.
3. Set free_cache to 10 via preloaded accepts on other queues, then request len 11 -> drop, reason 1. Release len 1 on any queue, then request len 11 -> accept.
4. MODE = 1 with LFSR compared at a known state: occ 200, len 100, excess 248 -> decision matches the reference-model LFSR comparison. Across 1000 such requests, the drop rate is within ±3% of 248/4096.
5. Release len 50 and accept len 20 on the same queue in the UPDATE cycle -> occupancy = old - 50 + 20, free_cache = old + 30.
6. Release len 5 on an empty queue -> occupancy stays 0 and err_underflow = 1. Assert rst_n mid-request -> no dec_valid, err_underflow = 0, free_cache = 2047.
